// File: rtl/fifo_rr_read_arbiter.sv
// fifo_rr_read_arbiter: drains NUM_SRC first-word-fall-through source FIFOs
// into one valid/ready stream. A granted source gets up to BURST reads.
// Each word is tagged with its source index and goes through a 2-entry skid buffer.
//
// Ports:
//   i_Clk, i_Rst_L  clock, synchronous active-low reset
//   i_Empty         per-source empty flag (may include same-cycle read lookahead)
//   i_Rd_Data       per-source read data, source k at [k*WIDTH +: WIDTH]
//   o_Rd_En         registered per-source read enable, one-hot or zero
//   o_Grant         one-hot source currently holding the grant
//   o_Data, o_Src   head word of the skid buffer and its source index
//   o_DV            o_Data/o_Src valid; popped when o_DV && i_Ready
//   i_Ready         consumer ready
//
// Build option: define FIFO_ARB_STRICT_PRIORITY_EN to replace round-robin
// selection with lowest-index-first selection. Ports and timing are unchanged.
module fifo_rr_read_arbiter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned BURST   = 4
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_L,
    input  logic [NUM_SRC-1:0]         i_Empty,
    input  logic [NUM_SRC*WIDTH-1:0]   i_Rd_Data,
    output logic [NUM_SRC-1:0]         o_Rd_En,
    output logic [NUM_SRC-1:0]         o_Grant,
    output logic [WIDTH-1:0]           o_Data,
    output logic [$clog2(NUM_SRC)-1:0] o_Src,
    output logic                       o_DV,
    input  logic                       i_Ready
);
    localparam int unsigned SRC_W = $clog2(NUM_SRC);
    localparam int unsigned CNT_W = $clog2(BURST + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_STREAM, S_RELEASE} state_t;

    state_t             r_state, w_state_next;
    logic [SRC_W-1:0]   r_rr_ptr, w_rr_ptr_next;
    logic [NUM_SRC-1:0] r_grant, w_grant_next;
    logic [NUM_SRC-1:0] r_rd_en, w_rd_en_next;
    logic [CNT_W-1:0]   r_burst_cnt, w_burst_cnt_next;
    logic [1:0]         r_occ, w_occ_next;
    logic [WIDTH-1:0]   r_head_data, w_head_data_next, r_tail_data, w_tail_data_next;
    logic [SRC_W-1:0]   r_head_src, w_head_src_next, r_tail_src, w_tail_src_next;
    logic               r_dv;

    logic               w_push, w_pop, w_any_avail, w_found, w_rd_ok;
    logic [SRC_W-1:0]   w_pick, w_cand, w_rd_idx;
    logic [WIDTH-1:0]   w_rd_word;

    // Read data arrives in the same cycle as the registered read enable
    always_comb begin
        w_rd_idx  = '0;
        w_rd_word = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (r_rd_en[k]) begin
                w_rd_idx  = SRC_W'(k);
                w_rd_word = i_Rd_Data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_push      = |r_rd_en;
    assign w_pop       = r_dv & i_Ready;
    assign w_occ_next  = r_occ + 2'(w_push) - 2'(w_pop);
    assign w_any_avail = ~&i_Empty;

    // Source selection for the ARB cycle
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
`ifdef FIFO_ARB_STRICT_PRIORITY_EN
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            w_cand = SRC_W'(k);
            if (!w_found && !i_Empty[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
`else
        // Search starts one past the last grant and wraps at NUM_SRC-1
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            w_cand = SRC_W'((32'(r_rr_ptr) + k) % NUM_SRC);
            if (!w_found && !i_Empty[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
`endif
    end

    // Next-state, grant, burst count and read issue
    always_comb begin
        w_state_next     = r_state;
        w_rr_ptr_next    = r_rr_ptr;
        w_grant_next     = r_grant;
        w_burst_cnt_next = r_burst_cnt + CNT_W'(w_push);
        w_rd_en_next     = '0;
        w_rd_ok          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_avail) w_state_next = S_ARB;
            end
            S_ARB: begin
                if (w_found) begin
                    w_grant_next     = NUM_SRC'(1) << w_pick;
                    w_rr_ptr_next    = w_pick;
                    w_burst_cnt_next = '0;
                    w_state_next     = S_STREAM;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_STREAM: begin
                // Issue only if the word can land in the skid buffer next cycle
                w_rd_ok = !i_Empty[r_rr_ptr] &&
                          (w_burst_cnt_next < CNT_W'(BURST)) &&
                          (w_occ_next <= 2'd1);
                if (w_rd_ok) w_rd_en_next = r_grant;
                // Leave as the last burst read is issued so the gap stays at two cycles
                if ((w_rd_ok && (w_burst_cnt_next == CNT_W'(BURST - 1))) ||
                    (w_burst_cnt_next >= CNT_W'(BURST)) ||
                    (i_Empty[r_rr_ptr] && !w_push)) begin
                    w_state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_grant_next = '0;
                w_state_next = w_any_avail ? S_ARB : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Skid buffer: head feeds the outputs, tail absorbs a read during a stall
    always_comb begin
        w_head_data_next = r_head_data;
        w_head_src_next  = r_head_src;
        w_tail_data_next = r_tail_data;
        w_tail_src_next  = r_tail_src;
        case ({w_push, w_pop})
            2'b10: begin
                if (r_occ == 2'd0) begin
                    w_head_data_next = w_rd_word;
                    w_head_src_next  = w_rd_idx;
                end else begin
                    w_tail_data_next = w_rd_word;
                    w_tail_src_next  = w_rd_idx;
                end
            end
            2'b01: begin
                w_head_data_next = r_tail_data;
                w_head_src_next  = r_tail_src;
            end
            2'b11: begin
                if (r_occ == 2'd1) begin
                    w_head_data_next = w_rd_word;
                    w_head_src_next  = w_rd_idx;
                end else begin
                    w_head_data_next = r_tail_data;
                    w_head_src_next  = r_tail_src;
                    w_tail_data_next = w_rd_word;
                    w_tail_src_next  = w_rd_idx;
                end
            end
            default: begin
            end
        endcase
    end

    // State register
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= SRC_W'(NUM_SRC - 1);
            r_grant     <= '0;
            r_rd_en     <= '0;
            r_burst_cnt <= '0;
            r_occ       <= '0;
            r_head_data <= '0;
            r_head_src  <= '0;
            r_tail_data <= '0;
            r_tail_src  <= '0;
            r_dv        <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rr_ptr    <= w_rr_ptr_next;
            r_grant     <= w_grant_next;
            r_rd_en     <= w_rd_en_next;
            r_burst_cnt <= w_burst_cnt_next;
            r_occ       <= w_occ_next;
            r_head_data <= w_head_data_next;
            r_head_src  <= w_head_src_next;
            r_tail_data <= w_tail_data_next;
            r_tail_src  <= w_tail_src_next;
            r_dv        <= (w_occ_next != 2'd0);
        end
    end

    assign o_Rd_En = r_rd_en;
    assign o_Grant = r_grant;
    assign o_Data  = r_head_data;
    assign o_Src   = r_head_src;
    assign o_DV    = r_dv;

endmodule

// File: tb/tb_fifo_rr_read_arbiter.sv
// Testbench for fifo_rr_read_arbiter: source FIFOs with read lookahead,
// a burst-level ordering model and a scoreboard on accepted words.
module tb_fifo_rr_read_arbiter;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned BURST   = 4;
    localparam int unsigned SRC_W   = $clog2(NUM_SRC);
    localparam int          DEPTH   = 64;

    logic                     i_Clk = 1'b0;
    logic                     i_Rst_L;
    logic [NUM_SRC-1:0]       i_Empty;
    logic [NUM_SRC*WIDTH-1:0] i_Rd_Data;
    logic [NUM_SRC-1:0]       o_Rd_En;
    logic [NUM_SRC-1:0]       o_Grant;
    logic [WIDTH-1:0]         o_Data;
    logic [SRC_W-1:0]         o_Src;
    logic                     o_DV;
    logic                     i_Ready;

    always #5 i_Clk = ~i_Clk;

    fifo_rr_read_arbiter #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .BURST(BURST)) dut (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Empty   (i_Empty),
        .i_Rd_Data (i_Rd_Data),
        .o_Rd_En   (o_Rd_En),
        .o_Grant   (o_Grant),
        .o_Data    (o_Data),
        .o_Src     (o_Src),
        .o_DV      (o_DV),
        .i_Ready   (i_Ready)
    );

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0]   mem [NUM_SRC][DEPTH];
    int                 head [NUM_SRC];
    int                 cnt  [NUM_SRC];
    logic [31:0]        exp_q [$];
    int                 acc_cyc_q [$];
    int                 acc_src_q [$];
    int                 cyc = 0;
    int                 model_ptr = NUM_SRC - 1;
    int                 ready_pct = 100;
    logic [NUM_SRC-1:0] grant_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int fifo_words();
        int s = 0;
        for (int k = 0; k < NUM_SRC; k++) s += cnt[k];
        return s;
    endfunction

    // Source FIFO outputs: head word, empty counts the read in progress
    task automatic drive();
        for (int k = 0; k < NUM_SRC; k++) begin
            i_Empty[k] = ((cnt[k] - (o_Rd_En[k] ? 1 : 0)) <= 0);
            i_Rd_Data[k*WIDTH +: WIDTH] = (cnt[k] > 0) ? mem[k][head[k]] : '0;
        end
    endtask

    task automatic clear_fifos();
        for (int k = 0; k < NUM_SRC; k++) begin
            cnt[k]  = 0;
            head[k] = 0;
        end
        exp_q.delete();
        acc_cyc_q.delete();
        acc_src_q.delete();
        grant_seen = '0;
    endtask

    task automatic load_src(input int k, input int n, input int base);
        if (cnt[k] == 0) head[k] = 0;
        for (int j = 0; j < n; j++) begin
            mem[k][head[k] + cnt[k]] = WIDTH'(base + j);
            cnt[k]++;
        end
    endtask

    // Expected word order from burst rules: next non-empty source, up to BURST words each
    task automatic model_build();
        int rem [NUM_SRC];
        int pos [NUM_SRC];
        int pick;
        int take;
        int c;
        bit done;
        for (int k = 0; k < NUM_SRC; k++) begin
            rem[k] = cnt[k];
            pos[k] = head[k];
        end
        done = 1'b0;
        while (!done) begin
            pick = -1;
`ifdef FIFO_ARB_STRICT_PRIORITY_EN
            for (int k = 0; k < NUM_SRC; k++)
                if (pick < 0 && rem[k] > 0) pick = k;
`else
            for (int i = 1; i <= NUM_SRC; i++) begin
                c = (model_ptr + i) % NUM_SRC;
                if (pick < 0 && rem[c] > 0) pick = c;
            end
`endif
            if (pick < 0) begin
                done = 1'b1;
            end else begin
                take = (rem[pick] < BURST) ? rem[pick] : BURST;
                for (int j = 0; j < take; j++)
                    exp_q.push_back((32'(pick) << WIDTH) | 32'(mem[pick][pos[pick] + j]));
                pos[pick] += take;
                rem[pick] -= take;
                model_ptr = pick;
            end
        end
    endtask

    // One clock: sample before the edge, update FIFOs and check after it
    task automatic tick();
        logic [NUM_SRC-1:0] rd_now, emp_now;
        logic               acc, dv_now, rst_now;
        logic [WIDTH-1:0]   d_now;
        logic [SRC_W-1:0]   s_now;
        logic [31:0]        exp_w;
        rd_now  = o_Rd_En;
        emp_now = i_Empty;
        acc     = o_DV && i_Ready;
        dv_now  = o_DV;
        d_now   = o_Data;
        s_now   = o_Src;
        rst_now = i_Rst_L;
        @(posedge i_Clk);
        #1;
        cyc++;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (rd_now[k] && cnt[k] > 0) begin
                head[k]++;
                cnt[k]--;
            end
        end
        if (rst_now) begin
            if (acc) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check("word", 32'({s_now, d_now}), exp_w);
                acc_cyc_q.push_back(cyc);
                acc_src_q.push_back(int'(s_now));
            end
            if (dv_now && !acc)
                check("hold", 32'({o_DV, o_Src, o_Data}), 32'({1'b1, s_now, d_now}));
            if (o_Rd_En != '0) begin
                check("rd_en_onehot", 32'($onehot(o_Rd_En)), 32'd1);
                check("rd_en_nonempty", 32'(o_Rd_En & emp_now), 32'd0);
            end
        end
        grant_seen = grant_seen | o_Grant;
        i_Ready = ($urandom_range(0, 99) < ready_pct);
        drive();
    endtask

    task automatic do_reset();
        ready_pct = 0;
        i_Ready   = 1'b0;
        i_Rst_L   = 1'b0;
        tick();
        tick();
        i_Rst_L = 1'b1;
        clear_fifos();
        model_ptr = NUM_SRC - 1;
        drive();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_words() != 0 || o_DV) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(n < budget), 32'd1);
        repeat (4) tick();
        check({tag, "_idle_grant"}, 32'(o_Grant), 32'd0);
        check({tag, "_idle_dv"}, 32'(o_DV), 32'd0);
        check({tag, "_idle_rd_en"}, 32'(o_Rd_En), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int ng;
        i_Rst_L = 1'b0;
        i_Ready = 1'b0;
        i_Empty = '1;
        i_Rd_Data = '0;
        clear_fifos();
        drive();

        // Reset values and idle with all sources empty
        do_reset();
        check("rst_dv", 32'(o_DV), 32'd0);
        check("rst_rd_en", 32'(o_Rd_En), 32'd0);
        check("rst_grant", 32'(o_Grant), 32'd0);
        check("rst_data", 32'(o_Data), 32'd0);
        check("rst_src", 32'(o_Src), 32'd0);
        repeat (20) tick();
        check("idle_dv", 32'(o_DV), 32'd0);
        check("idle_rd_en", 32'(o_Rd_En), 32'd0);
        check("idle_grant", 32'(grant_seen), 32'd0);

        // Single source with three words
        do_reset();
        ready_pct = 100;
        i_Ready = 1'b1;
        load_src(2, 3, 'hA1);
        model_build();
        drive();
        drain("single", 200);
        check("single_count", 32'(acc_cyc_q.size()), 32'd3);
        if (acc_cyc_q.size() == 3) begin
            check("single_b2b_1", 32'(acc_cyc_q[1] - acc_cyc_q[0]), 32'd1);
            check("single_b2b_2", 32'(acc_cyc_q[2] - acc_cyc_q[1]), 32'd1);
        end
        check("single_grant", 32'(grant_seen), 32'h4);

        // All sources full, full-rate consumer
        do_reset();
        ready_pct = 100;
        i_Ready = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) load_src(k, 10, k * 16);
        model_build();
        drive();
        drain("rr_full", 1000);
        check("rr_full_count", 32'(acc_cyc_q.size()), 32'd40);
`ifndef FIFO_ARB_STRICT_PRIORITY_EN
        ng = 0;
        for (int i = 1; i < acc_cyc_q.size(); i++) begin
            if (acc_src_q[i] != acc_src_q[i-1] && ng < 4) begin
                check("rr_gap", 32'(acc_cyc_q[i] - acc_cyc_q[i-1] - 1), 32'd2);
                ng++;
            end
        end
        check("rr_gap_seen", 32'(ng), 32'd4);
`endif

        // Consumer stall in the middle of a src1 burst
        do_reset();
        ready_pct = 100;
        i_Ready = 1'b1;
        load_src(1, 8, 'h10);
        model_build();
        drive();
        n = 0;
        while (acc_cyc_q.size() < 2 && n < 100) begin
            tick();
            n++;
        end
        check("stall_start", 32'(n < 100), 32'd1);
        ready_pct = 0;
        i_Ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_dv", 32'(o_DV), 32'd1);
            if (i >= 1) check("stall_rd_en", 32'(o_Rd_En), 32'd0);
        end
        ready_pct = 100;
        i_Ready = 1'b1;
        drain("stall", 200);
        check("stall_count", 32'(acc_cyc_q.size()), 32'd8);

        // Reset in the middle of a src3 burst
        do_reset();
        ready_pct = 100;
        i_Ready = 1'b1;
        load_src(3, 8, 'h30);
        model_build();
        drive();
        n = 0;
        while (acc_cyc_q.size() < 1 && n < 100) begin
            tick();
            n++;
        end
        check("src3_grant", 32'(o_Grant), 32'h8);
        ready_pct = 0;
        i_Ready = 1'b0;
        i_Rst_L = 1'b0;
        tick();
        check("rst_mid_dv", 32'(o_DV), 32'd0);
        check("rst_mid_grant", 32'(o_Grant), 32'd0);
        check("rst_mid_rd_en", 32'(o_Rd_En), 32'd0);
        i_Rst_L = 1'b1;
        clear_fifos();
        model_ptr = NUM_SRC - 1;
        ready_pct = 100;
        i_Ready = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) load_src(k, 2, 'h40 + k * 8);
        model_build();
        drive();
        drain("restart", 500);
        check("restart_first_src",
              (acc_src_q.size() > 0) ? 32'(acc_src_q[0]) : 32'hFFFF_FFFF, 32'd0);

        // Random fills with a random-ready consumer
        for (int r = 0; r < 6; r++) begin
            acc_cyc_q.delete();
            acc_src_q.delete();
            ready_pct = 60;
            for (int k = 0; k < NUM_SRC; k++)
                load_src(k, int'($urandom_range(0, 12)), int'($urandom_range(0, 255)));
            model_build();
            drive();
            drain("random", 2000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rr_read_arbiter.md
Name: fifo_rr_read_arbiter

Overview:
Round-robin scheduler that drains NUM_SRC synchronous register FIFOs into one valid/ready output stream.
- Issues FIFO read enables and captures the first-word-fall-through read data.
- Tags each word with its source index and enforces a per-grant burst limit so no source starves the others.
- Sits between per-channel ingress FIFOs and a shared downstream consumer (UART TX or packet formatter).

Parameters:
WIDTH, 8, data word width
NUM_SRC, 4, number of source FIFOs (2..8)
BURST, 4, maximum words read per grant (1..15)

Ports:
i_Clk  in  1  clock
i_Rst_L  in  1  synchronous active-low reset
i_Empty  in  NUM_SRC  empty flag of each source FIFO; bit k belongs to FIFO k
i_Rd_Data  in  NUM_SRC*WIDTH  read data of each source FIFO; FIFO k occupies bits [k*WIDTH +: WIDTH]
o_Rd_En  out  NUM_SRC  read enable to each source FIFO; registered, one-hot or zero
o_Grant  out  NUM_SRC  one-hot source currently granted
o_Data  out  WIDTH  output word
o_Src  out  $clog2(NUM_SRC)  source index of o_Data
o_DV  out  1  o_Data/o_Src valid
i_Ready  in  1  consumer accepts the word when o_DV && i_Ready

Behaviour:
- Clock and reset: single clock i_Clk. Reset is synchronous, active-low on i_Rst_L, sampled only at posedge i_Clk.
- Reset values:
  - o_Rd_En=0, o_Grant=0, o_DV=0, o_Data=0, o_Src=0.
  - State=IDLE, RR pointer=NUM_SRC-1, so source 0 wins first.
  - Burst count=0, buffer occupancy=0.
- Output buffer: 2-entry skid FIFO. o_Data/o_Src/o_DV come from its head.
  - Pop when o_DV && i_Ready.
  - o_Data and o_Src hold stable while o_DV=1 and i_Ready=0.
- Read capture: source FIFO data is valid in the same cycle its o_Rd_En is high. At that posedge the arbiter writes i_Rd_Data slice k and index k into the skid buffer.
  - Read-to-o_DV latency is 1 cycle when the buffer is empty.
- Read issue: o_Rd_En_next[k] = grant[k] && state==STREAM && !i_Empty[k] && burst_cnt_next<BURST && (occupancy + o_Rd_En_now - pop_now) <= 1.
  - o_Rd_En is registered, so there is no combinational path from i_Empty to o_Rd_En.
  - i_Empty may include the FIFO's own same-cycle read lookahead; it must be correct for "empty after the read in progress".
  - Sustained rate: one word per clock per source while i_Ready=1.
- States:
  - IDLE: if any ~i_Empty bit is set, go to ARB. Otherwise stay.
  - ARB (1 cycle): choose the first non-empty source searching from RR pointer+1 with wraparound. Set o_Grant and the RR pointer to it, clear burst_cnt, go to STREAM.
    - If all sources are empty in this cycle, go to IDLE.
  - STREAM: burst_cnt increments on each o_Rd_En. Go to RELEASE when either:
    - burst_cnt reaches BURST, or
    - i_Empty[grant]=1 with o_Rd_En=0 (source drained).
  - RELEASE (1 cycle): clear o_Grant. No reads are issued. Go to ARB if any source is non-empty, else IDLE.
- Boundaries:
  - Backpressure: a stall in STREAM does not advance burst_cnt. The grant is held until the burst completes or the source drains.
  - A source that becomes non-empty while another holds the grant waits for RELEASE.
  - o_Rd_En is never asserted to a source whose i_Empty was 1 in the issuing cycle.
  - Single active source: it is re-granted after each RELEASE, giving BURST words per 2 idle cycles of gap.
  - Reset mid-burst: all state is cleared at that edge, buffered words are discarded, and o_Rd_En drops the next cycle.
  - NUM_SRC not a power of two: RR wrap happens at NUM_SRC-1.

Optional Feature:
Macro FIFO_ARB_STRICT_PRIORITY_EN.
- Defined: ARB chooses the lowest-index non-empty source. The RR pointer is unused. A higher-priority source still waits for the current burst to end.
- Undefined: round-robin as above.
- Port list and timing are identical in both cases.

Test Plan:
- Reset, then all i_Empty=1 -> o_DV=0, o_Rd_En=0, o_Grant=0 indefinitely; state stays IDLE.
- Source 2 holds 3 words (0xA1,0xA2,0xA3), i_Ready=1 -> o_Grant=4'b0100. Output is A1,A2,A3 on consecutive cycles with o_Src=2, followed by RELEASE then IDLE.
- All 4 sources hold 10 words, BURST=4, i_Ready=1 -> output order is 4 words from src0, then 4 from src1, then 4 from src2, 4 from src3, then src0 again. There are 2 non-DV cycles between bursts.
- Src1 streaming, i_Ready low for 5 cycles mid-burst -> at most 2 words are buffered, o_Rd_En=0 during the stall, o_Data is held stable, and no word is lost or duplicated after release.
- i_Rst_L driven low in the middle of a src3 burst -> the next cycle has o_DV=0, o_Grant=0, o_Rd_En=0; after release, arbitration restarts at src0.
- With FIFO_ARB_STRICT_PRIORITY_EN defined, src0 and src3 both non-empty -> src0 is served repeatedly and src3 is granted only once src0 is empty at ARB.
